// File: rtl/seven_seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_pkg
// Purpose : shared constants and types for the multiplexed seven-segment
//           scanner. Segment codes are active-low {dp,g,f,e,d,c,b,a} with the
//           decimal point off (bit 7 = 1).
// Ports   : none (package).
// Config  : none here; the top honours SEVEN_SEG_BLINK_EN.
// -----------------------------------------------------------------------------
package seven_seg_scan_pkg;

  // All segments and decimal point off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment patterns per hex value, dp off.
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  // What the current slot should drive on the pins.
  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,  // anti-ghosting window at slot start
    PH_LIT   = 2'd1,  // digit enabled: drive its column and segments
    PH_DARK  = 2'd2   // digit disabled (or blinked off): stay dark
  } slot_phase_e;

  // Combine a 7-bit active-low segment pattern with an active-high dp request.
  function automatic logic [7:0] seg_with_dp(input logic [6:0] seg_n, input logic dp_on);
    return {~dp_on, seg_n};
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_if
// Purpose : groups the load-side data bus and the pin-side outputs of the
//           scanner.
// Signals : load (1-cycle capture strobe), digit_data (4 bits per digit),
//           digit_en / dp_en / blink (per-digit masks), display_column
//           (active-low columns), out (active-low segments, out[7]=dp),
//           frame_done (1-cycle frame boundary pulse).
// Modports: master = controller driving data, slave = scanner.
// -----------------------------------------------------------------------------
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digit_data;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic [NUM_DIGITS-1:0]     dp_en;
  logic [NUM_DIGITS-1:0]     blink;
  logic [NUM_DIGITS-1:0]     display_column;
  logic [7:0]                out;
  logic                      frame_done;

  modport master (
    output load, digit_data, digit_en, dp_en, blink,
    input  display_column, out, frame_done
  );

  modport slave (
    input  load, digit_data, digit_en, dp_en, blink,
    output display_column, out, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_decode
// Purpose : combinational hex nibble to active-low 7-segment pattern.
// Ports   : hex   in  4  value 0..F
//           seg_n out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seven_seg_decode
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Table lookup of the segment pattern for one nibble.
  always_comb begin
    seg_n = SEG_BLANK[6:0];
    case (hex)
      4'h0:    seg_n = SEG_HEX_0[6:0];
      4'h1:    seg_n = SEG_HEX_1[6:0];
      4'h2:    seg_n = SEG_HEX_2[6:0];
      4'h3:    seg_n = SEG_HEX_3[6:0];
      4'h4:    seg_n = SEG_HEX_4[6:0];
      4'h5:    seg_n = SEG_HEX_5[6:0];
      4'h6:    seg_n = SEG_HEX_6[6:0];
      4'h7:    seg_n = SEG_HEX_7[6:0];
      4'h8:    seg_n = SEG_HEX_8[6:0];
      4'h9:    seg_n = SEG_HEX_9[6:0];
      4'hA:    seg_n = SEG_HEX_A[6:0];
      4'hB:    seg_n = SEG_HEX_B[6:0];
      4'hC:    seg_n = SEG_HEX_C[6:0];
      4'hD:    seg_n = SEG_HEX_D[6:0];
      4'hE:    seg_n = SEG_HEX_E[6:0];
      4'hF:    seg_n = SEG_HEX_F[6:0];
      default: seg_n = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
// Purpose : time-multiplexed N-digit seven-segment scanner. New data is
//           captured into a pending buffer on load and promoted to the active
//           buffer only at a frame boundary, so a frame never mixes old and
//           new content. Each slot begins with BLANK_CYC cycles of all columns
//           off to suppress ghosting.
// Ports   : clk    in  system clock
//           reset  in  asynchronous, active-high
//           bus    slave modport of seven_seg_scan_if (load/data/masks in,
//                  display_column/out/frame_done out)
// Config  : SEVEN_SEG_BLINK_EN - when defined, a frame counter blanks digits
//           with blink set during the second half of each blink period.
// -----------------------------------------------------------------------------
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic           clk,
  input  logic           reset,
  seven_seg_scan_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COL_OFF    = {NUM_DIGITS{1'b1}};

  // Scan position.
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_tick_s, frame_tick_s;

  // Double buffer.
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;

  // Registered pin drivers.
  logic [NUM_DIGITS-1:0] col_q, col_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;

  // Per-slot decode.
  logic [3:0]   nibble_s;
  logic [6:0]   hex_seg_s;
  logic         digit_lit_s;
  slot_phase_e  phase_s;

  // Prescaler and slot index advance; frame_done is timed from the next state
  // so the registered pulse lines up with the boundary cycle itself.
  always_comb begin
    slot_tick_s  = (presc_q == PRESC_LAST);
    frame_tick_s = slot_tick_s && (idx_q == IDX_LAST);
    presc_d      = presc_q;
    idx_d        = idx_q;
    if (slot_tick_s) begin
      presc_d = {PW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
    fd_d = (presc_d == PRESC_LAST) && (idx_d == IDX_LAST);
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);

  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                  blink_off_s;

  // Frame counter across one full blink period plus blink mask buffering,
  // which follows exactly the same promotion rules as digit_en.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    act_blink_d  = act_blink_q;
    pend_blink_d = pend_blink_q;
    if (frame_tick_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
      end else begin
        blink_cnt_d = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
    if (frame_tick_s && bus.load) begin
      act_blink_d = bus.blink;
    end else if (frame_tick_s && pend_vld_q) begin
      act_blink_d = pend_blink_q;
    end else if (bus.load) begin
      pend_blink_d = bus.blink;
    end else begin
      pend_blink_d = pend_blink_q;
    end
    blink_off_s = (blink_cnt_q >= BLINK_HALF);
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q  <= {BW{1'b0}};
      act_blink_q  <= {NUM_DIGITS{1'b0}};
      pend_blink_q <= {NUM_DIGITS{1'b0}};
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      act_blink_q  <= act_blink_d;
      pend_blink_q <= pend_blink_d;
    end
  end

  // A blinking digit in its off half-period behaves as disabled.
  always_comb begin
    digit_lit_s = act_en_q[idx_q] && !(act_blink_q[idx_q] && blink_off_s);
  end
`else
  logic cfg_unused;

  // Blink input and period are accepted but have no effect in this build.
  assign cfg_unused = ^{bus.blink, BLINK_FRAMES[0]};

  // Digit visibility comes straight from the active enable mask.
  always_comb begin
    digit_lit_s = act_en_q[idx_q];
  end
`endif

  // Double buffer: a load on the boundary bypasses straight to active;
  // otherwise pending data is promoted on the boundary, and loads in between
  // just overwrite the pending copy.
  always_comb begin
    act_data_d  = act_data_q;
    act_en_d    = act_en_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    if (frame_tick_s && bus.load) begin
      act_data_d = bus.digit_data;
      act_en_d   = bus.digit_en;
      act_dp_d   = bus.dp_en;
      pend_vld_d = 1'b0;
    end else if (frame_tick_s && pend_vld_q) begin
      act_data_d = pend_data_q;
      act_en_d   = pend_en_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pend_data_d = bus.digit_data;
      pend_en_d   = bus.digit_en;
      pend_dp_d   = bus.dp_en;
      pend_vld_d  = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  seven_seg_decode u_decode (
    .hex   (nibble_s),
    .seg_n (hex_seg_s)
  );

  // Pick the current slot's nibble and decide what the pins show next cycle.
  always_comb begin
    nibble_s = act_data_q[{idx_q, 2'b00} +: 4];
    if (int'(presc_q) < BLANK_CYC) begin
      phase_s = PH_BLANK;
    end else if (digit_lit_s) begin
      phase_s = PH_LIT;
    end else begin
      phase_s = PH_DARK;
    end
    col_d = COL_OFF;
    seg_d = SEG_BLANK;
    case (phase_s)
      PH_LIT: begin
        col_d[idx_q] = 1'b0;
        seg_d        = seg_with_dp(hex_seg_s, act_dp_q[idx_q]);
      end
      PH_BLANK, PH_DARK: begin
        col_d = COL_OFF;
        seg_d = SEG_BLANK;
      end
      default: begin
        col_d = COL_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= {PW{1'b0}};
      idx_q       <= {IW{1'b0}};
      act_data_q  <= {(4*NUM_DIGITS){1'b0}};
      act_en_q    <= {NUM_DIGITS{1'b0}};
      act_dp_q    <= {NUM_DIGITS{1'b0}};
      pend_data_q <= {(4*NUM_DIGITS){1'b0}};
      pend_en_q   <= {NUM_DIGITS{1'b0}};
      pend_dp_q   <= {NUM_DIGITS{1'b0}};
      pend_vld_q  <= 1'b0;
      col_q       <= COL_OFF;
      seg_q       <= SEG_BLANK;
      fd_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_en_q    <= act_en_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      col_q       <= col_d;
      seg_q       <= seg_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.display_column = col_q;
  assign bus.out            = seg_q;
  assign bus.frame_done     = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
// Purpose : directed self-checking bench for seven_seg_scan with 4 digits,
//           4 cycles per slot and 1 blank cycle. Blink steps are included
//           when SEVEN_SEG_BLINK_EN is defined.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load strobe, driven at a falling edge and captured on the next rise.
  task automatic pulse_load(input logic [15:0] data, input logic [3:0] en,
                            input logic [3:0] dp, input logic [3:0] blk);
    bus.digit_data = data;
    bus.digit_en   = en;
    bus.dp_en      = dp;
    bus.blink      = blk;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  // Leaves the bench at the falling edge where frame_done is high.
  task automatic wait_fd();
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_timeout", {31'd0, bus.frame_done}, 32'd1);
  endtask

  // From the boundary edge, step one cycle and confirm the pulse dropped.
  task automatic start_frame();
    @(negedge clk);
    chk("frame_done_width", {31'd0, bus.frame_done}, 32'd0);
  endtask

  // Four samples of one slot: blank first, then the expected drive.
  task automatic check_slot(input int j, input logic [3:0] col, input logic [7:0] seg);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      if (p == 0) begin
        chk($sformatf("slot%0d_blank_col", j), {28'd0, bus.display_column}, 32'h0000000F);
        chk($sformatf("slot%0d_blank_out", j), {24'd0, bus.out}, 32'h000000FF);
      end else begin
        chk($sformatf("slot%0d_p%0d_col", j, p), {28'd0, bus.display_column}, {28'd0, col});
        chk($sformatf("slot%0d_p%0d_out", j, p), {24'd0, bus.out}, {24'd0, seg});
      end
    end
  endtask

  // A whole frame, starting one cycle after its opening boundary.
  task automatic check_slots(input logic [15:0] cols, input logic [31:0] segs);
    for (int j = 0; j < 4; j++) begin
      check_slot(j, cols[4*j +: 4], segs[8*j +: 8]);
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.load       = 1'b0;
    bus.digit_data = 16'h0000;
    bus.digit_en   = 4'h0;
    bus.dp_en      = 4'h0;
    bus.blink      = 4'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_col", {28'd0, bus.display_column}, 32'h0000000F);
    chk("reset_out", {24'd0, bus.out}, 32'h000000FF);
    chk("reset_fd",  {31'd0, bus.frame_done}, 32'd0);
    reset = 1'b0;

    // Basic load: 1850 appears after the first boundary.
    pulse_load(16'h1850, 4'hF, 4'h0, 4'h0);
    wait_fd();
    start_frame();
    check_slots(16'h7BDE, 32'hF98092C0);

    // Two mid-frame loads: current frame keeps 1850, next shows 0007.
    pulse_load(16'h1850, 4'hF, 4'h0, 4'h0);
    pulse_load(16'h0007, 4'hF, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    check_slot(1, 4'hD, 8'h92);
    check_slot(2, 4'hB, 8'h80);
    check_slot(3, 4'h7, 8'hF9);
    check_slots(16'h7BDE, 32'hC0C0C0F8);

    // Partial enable with decimal point on digit 0.
    pulse_load(16'h0088, 4'b0011, 4'b0001, 4'h0);
    wait_fd();
    start_frame();
    check_slots(16'hFFDE, 32'hFFFF8000);

    // Load on the boundary cycle goes straight to the next frame.
    wait_fd();
    bus.digit_data = 16'hAAAA;
    bus.digit_en   = 4'hF;
    bus.dp_en      = 4'h0;
    bus.blink      = 4'h0;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
    chk("bypass_fd_width", {31'd0, bus.frame_done}, 32'd0);
    check_slots(16'h7BDE, 32'h88888888);

    // Reset mid-slot while digit 0 is lit.
    repeat (2) @(negedge clk);
    chk("prereset_col", {28'd0, bus.display_column}, 32'h0000000E);
    chk("prereset_out", {24'd0, bus.out}, 32'h00000088);
    #2 reset = 1'b1;
    #1;
    chk("midreset_col", {28'd0, bus.display_column}, 32'h0000000F);
    chk("midreset_out", {24'd0, bus.out}, 32'h000000FF);
    chk("midreset_fd",  {31'd0, bus.frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("restart_frame_len", n, 32'd15);
    start_frame();
    check_slots(16'hFFFF, 32'hFFFFFFFF);

`ifdef SEVEN_SEG_BLINK_EN
    // Blink counter is at frame 2; this load takes effect in frame 3.
    pulse_load(16'h0000, 4'b0001, 4'h0, 4'b0001);
    wait_fd();
    start_frame();
    check_slots(16'hFFFF, 32'hFFFFFFFF);
    check_slots(16'hFFFE, 32'hFFFFFFC0);
    check_slots(16'hFFFE, 32'hFFFFFFC0);
    check_slots(16'hFFFF, 32'hFFFFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
